// File: rtl/pipeline_buf.sv
// pipeline_buf: circular-buffer pipeline stage with valid/allow handshaking.
// Data pushed into an empty buffer is visible on out one cycle later; there is
// no combinational path from in to out. allow_in is either purely registered
// (READY_REG=1) or may also follow allow_out (READY_REG=0).
module pipeline_buf #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2,
  parameter int READY_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         allow_in,
  input  logic [WIDTH-1:0]             in,
  output logic                         valid_out,
  input  logic                         allow_out,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_full;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign not_full = (count_q != FULL);

  if (READY_REG != 0) begin : g_ready_reg
    assign allow_in = not_full;
  end else begin : g_ready_comb
    // A full buffer can still accept when the head leaves this same cycle.
    assign allow_in = not_full | allow_out;
  end

  assign valid_out = (count_q != '0);
  assign push      = valid_in & allow_in & ~flush;
  assign pop       = valid_out & allow_out & ~flush;
  assign out       = valid_out ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  // Next-state for pointers and occupancy from the push/pop decisions.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset dominates, flush empties the buffer, else advance.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; unreset because out is gated by valid_out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

endmodule

// File: tb/tb_pipeline_buf.sv
// tb_pipeline_buf: four pipeline_buf configurations driven by common
// handshake stimulus, each compared against a queue-based reference model.
module tb_pipeline_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s, flush_s, valid_in_s, allow_out_s;
  logic [7:0] din [4];

  logic       ai0, ai1, ai2, ai3;
  logic       vo0, vo1, vo2, vo3;
  logic [7:0] ou0, ou1, ou2, ou3;
  logic [1:0] c0, c1, c2;
  logic [0:0] c3;

  logic       ai [4];
  logic       vo [4];
  logic [7:0] ou [4];
  logic [2:0] cn [4];

  assign ai[0] = ai0; assign ai[1] = ai1; assign ai[2] = ai2; assign ai[3] = ai3;
  assign vo[0] = vo0; assign vo[1] = vo1; assign vo[2] = vo2; assign vo[3] = vo3;
  assign ou[0] = ou0; assign ou[1] = ou1; assign ou[2] = ou2; assign ou[3] = ou3;
  assign cn[0] = {1'b0, c0};
  assign cn[1] = {1'b0, c1};
  assign cn[2] = {1'b0, c2};
  assign cn[3] = {2'b00, c3};

  localparam int DEP [4] = '{2, 2, 3, 1};
  localparam int RR  [4] = '{1, 0, 1, 0};

  pipeline_buf #(.WIDTH(8), .DEPTH(2), .READY_REG(1)) u0 (
    .clk(clk), .reset(reset_s), .flush(flush_s), .valid_in(valid_in_s),
    .allow_in(ai0), .in(din[0]), .valid_out(vo0), .allow_out(allow_out_s),
    .out(ou0), .count(c0));
  pipeline_buf #(.WIDTH(8), .DEPTH(2), .READY_REG(0)) u1 (
    .clk(clk), .reset(reset_s), .flush(flush_s), .valid_in(valid_in_s),
    .allow_in(ai1), .in(din[1]), .valid_out(vo1), .allow_out(allow_out_s),
    .out(ou1), .count(c1));
  pipeline_buf #(.WIDTH(8), .DEPTH(3), .READY_REG(1)) u2 (
    .clk(clk), .reset(reset_s), .flush(flush_s), .valid_in(valid_in_s),
    .allow_in(ai2), .in(din[2]), .valid_out(vo2), .allow_out(allow_out_s),
    .out(ou2), .count(c2));
  pipeline_buf #(.WIDTH(8), .DEPTH(1), .READY_REG(0)) u3 (
    .clk(clk), .reset(reset_s), .flush(flush_s), .valid_in(valid_in_s),
    .allow_in(ai3), .in(din[3]), .valid_out(vo3), .allow_out(allow_out_s),
    .out(ou3), .count(c3));

  // Reference model: one FIFO queue per instance.
  logic [7:0] mq [4][$];
  int         tests = 0;
  int         fails = 0;
  int         xfer3;
  int         maxc2;
  bit         collect;
  bit         pushed [4];
  logic [7:0] got [$];
  int         nxt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_allow(input int i);
    return (mq[i].size() < DEP[i]) || (RR[i] == 0 && allow_out_s);
  endfunction

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int sz;
      logic [7:0] head;
      sz   = mq[i].size();
      head = 8'h00;
      if (sz != 0) head = mq[i][0];
      chk($sformatf("allow_in[%0d]", i),  32'(ai[i]), 32'(m_allow(i)));
      chk($sformatf("valid_out[%0d]", i), 32'(vo[i]), 32'(sz != 0));
      chk($sformatf("out[%0d]", i),       32'(ou[i]), 32'(head));
      chk($sformatf("count[%0d]", i),     32'(cn[i]), 32'(sz));
    end
    if (int'(cn[2]) > maxc2) maxc2 = int'(cn[2]);
  endtask

  task automatic set_all(input logic [7:0] d);
    for (int i = 0; i < 4; i++) din[i] = d;
  endtask

  task automatic drive(input bit vin, input bit aout, input bit fl, input bit rst);
    valid_in_s  = vin;
    allow_out_s = aout;
    flush_s     = fl;
    reset_s     = rst;
    #1;
    check_all();
  endtask

  // Advance the model and observed-transfer tallies, then cross the edge.
  task automatic tick();
    bit live;
    live = !reset_s && !flush_s;
    if (live && vo[3] && allow_out_s) xfer3++;
    if (live && collect && vo[2] && allow_out_s) got.push_back(ou[2]);
    for (int i = 0; i < 4; i++) begin
      bit v, a;
      v = (mq[i].size() != 0);
      a = m_allow(i);
      pushed[i] = 1'b0;
      if (!live) begin
        mq[i].delete();
      end else begin
        if (v && allow_out_s) void'(mq[i].pop_front());
        if (valid_in_s && a) begin
          mq[i].push_back(din[i]);
          pushed[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_s = 1'b1; flush_s = 1'b0; valid_in_s = 1'b0; allow_out_s = 1'b0;
    set_all(8'h00);
    collect = 1'b0; xfer3 = 0; maxc2 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Post-reset state
    drive(0, 0, 0, 0);
    chk("rst_valid_out", 32'(vo0), 32'd0);
    chk("rst_out",       32'(ou0), 32'd0);
    chk("rst_count",     32'(cn[0]), 32'd0);
    chk("rst_allow_in",  32'(ai0), 32'd1);
    tick();

    // Fill then drain, DEPTH=2 READY_REG=1
    set_all(8'hA1); drive(1, 0, 0, 0);
    chk("latency_no_bypass", 32'(vo0), 32'd0);
    tick();
    set_all(8'hA2); drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("fill_count",    32'(cn[0]), 32'd2);
    chk("fill_allow_in", 32'(ai0), 32'd0);
    chk("fill_head",     32'(ou0), 32'hA1);
    tick();
    drive(0, 1, 0, 0); chk("drain_first", 32'(ou0), 32'hA1); tick();
    drive(0, 1, 0, 0); chk("drain_second", 32'(ou0), 32'hA2); tick();
    drive(0, 1, 0, 0); chk("drain_empty", 32'(cn[0]), 32'd0); tick();

    // Full pass-through, DEPTH=2 READY_REG=0
    drive(0, 0, 1, 0); tick();
    set_all(8'hB1); drive(1, 0, 0, 0); tick();
    set_all(8'hB2); drive(1, 0, 0, 0); tick();
    set_all(8'hB3); drive(1, 1, 0, 0);
    chk("pass_allow_in", 32'(ai1), 32'd1);
    tick();
    drive(0, 1, 0, 0);
    chk("pass_count", 32'(cn[1]), 32'd2);
    chk("pass_head",  32'(ou1), 32'hB2);
    tick();
    drive(0, 1, 0, 0); chk("pass_b3", 32'(ou1), 32'hB3); tick();
    drive(0, 1, 0, 0); chk("pass_empty", 32'(cn[1]), 32'd0); tick();

    // Flush with a same-cycle push
    drive(0, 0, 1, 0); tick();
    set_all(8'hC1); drive(1, 0, 0, 0); tick();
    set_all(8'hC2); drive(1, 0, 0, 0); tick();
    set_all(8'hCC); drive(1, 0, 1, 0);
    chk("flush_pre_count", 32'(cn[0]), 32'd2);
    chk("flush_pre_valid", 32'(vo0), 32'd1);
    chk("flush_pre_allow", 32'(ai0), 32'd0);
    tick();
    drive(0, 0, 0, 0);
    chk("flush_count", 32'(cn[0]), 32'd0);
    chk("flush_valid", 32'(vo0), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0);
      chk("flush_no_cc", 32'(vo1), 32'd0);
      tick();
    end

    // Reset mid-operation
    set_all(8'hD1); drive(1, 0, 0, 0); tick();
    set_all(8'hD2); drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("mid_rst_valid", 32'(vo0), 32'd0);
    chk("mid_rst_out",   32'(ou0), 32'd0);
    chk("mid_rst_allow", 32'(ai0), 32'd1);
    chk("mid_rst_count", 32'(cn[0]), 32'd0);
    tick();
    set_all(8'hE1); drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("post_rst_head",  32'(ou0), 32'hE1);
    chk("post_rst_count", 32'(cn[0]), 32'd1);
    tick();

    // Continuous throughput, DEPTH=1 READY_REG=0
    drive(0, 0, 1, 0); tick();
    xfer3 = 0;
    for (int k = 0; k < 8; k++) begin
      set_all(8'(k + 16));
      drive(1, 1, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0); tick();
    chk("throughput_xfers", 32'(xfer3), 32'd8);

    // Wrap-around ordering, DEPTH=3, random allow_out
    drive(0, 0, 1, 0); tick();
    for (int i = 0; i < 4; i++) nxt[i] = 1;
    got.delete();
    maxc2   = 0;
    collect = 1'b1;
    for (int c = 0; c < 400 && got.size() < 10; c++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'(nxt[i]);
      drive(($urandom % 4) != 0, ($urandom % 2) != 0, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) if (pushed[i]) nxt[i]++;
    end
    collect = 1'b0;
    chk("wrap_received", 32'(got.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++)
      if (k < got.size()) chk($sformatf("wrap_order[%0d]", k), 32'(got[k]), 32'(k + 1));
    chk("wrap_max_count", 32'(maxc2 <= 3), 32'd1);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 250; c++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
      drive(($urandom % 3) != 0, ($urandom % 3) != 0,
            ($urandom % 14) == 0, ($urandom % 60) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
